// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg
//   Shared types and constants for the interrupt request controller.
//   ic_state_t         : handshake FSM states (idle / request presented / in service)
//   IC_DEFAULT_SOURCES : default number of interrupt sources
package int_ctrl_pkg;

    typedef enum logic [1:0] {
        IC_IDLE,
        IC_REQUEST,
        IC_SERVICE
    } ic_state_t;

    localparam int unsigned IC_DEFAULT_SOURCES = 4;

endpackage

// File: rtl/int_priority_encoder.sv
// int_priority_encoder
//   Combinational fixed-priority encoder; the lowest set index wins.
//   Ports:
//     req   in  N_SOURCES  request vector
//     valid out 1          any bit of req set
//     idx   out ID_W       index of lowest set bit (0 when valid=0)
module int_priority_encoder
    import int_ctrl_pkg::*;
#(
    parameter int unsigned N_SOURCES = IC_DEFAULT_SOURCES,
    parameter int unsigned ID_W      = $clog2(N_SOURCES)
) (
    input  logic [N_SOURCES-1:0] req,
    output logic                 valid,
    output logic [ID_W-1:0]      idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        // Scan from the top down so the lowest set bit is written last.
        for (int unsigned i = N_SOURCES; i > 0; i--) begin
            if (req[i-1]) begin
                valid = 1'b1;
                idx   = ID_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/int_request_controller.sv
// int_request_controller
//   Latches interrupt pulses as pending flags, masks them, arbitrates by fixed
//   priority and presents one request to the CPU over an irq/ack/done handshake.
//   Optional feature: define INT_OVERFLOW_FLAG_EN to record sticky lost-request
//   flags; without it overflow_flags is tied to 0.
//   Ports:
//     clk, rst_n      clock (rising edge), async active-low reset
//     int_req         1-cycle request pulses, bit i = source i
//     int_mask        per-source enable
//     global_enable   master interrupt enable
//     clear_pending   software clear pulses for pending flags
//     cpu_irq         level request to CPU
//     cpu_irq_id      id of presented / in-service source
//     cpu_irq_ack     CPU accepted request
//     cpu_irq_done    CPU returned from handler
//     pending_flags   current pending flags
//     in_service      high between accepted ack and done
//     overflow_flags  sticky lost-request flags
module int_request_controller
    import int_ctrl_pkg::*;
#(
    parameter int unsigned N_SOURCES = IC_DEFAULT_SOURCES,
    parameter int unsigned ID_W      = $clog2(N_SOURCES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_SOURCES-1:0] int_req,
    input  logic [N_SOURCES-1:0] int_mask,
    input  logic                 global_enable,
    input  logic [N_SOURCES-1:0] clear_pending,
    output logic                 cpu_irq,
    output logic [ID_W-1:0]      cpu_irq_id,
    input  logic                 cpu_irq_ack,
    input  logic                 cpu_irq_done,
    output logic [N_SOURCES-1:0] pending_flags,
    output logic                 in_service,
    output logic [N_SOURCES-1:0] overflow_flags
);

    ic_state_t              state, state_next;
    logic [ID_W-1:0]        id_next;
    logic                   enc_valid;
    logic [ID_W-1:0]        enc_idx;
    logic                   accept;
    logic [N_SOURCES-1:0]   clr_vec;
    logic [N_SOURCES-1:0]   pending_next;

    int_priority_encoder #(
        .N_SOURCES (N_SOURCES),
        .ID_W      (ID_W)
    ) u_prio (
        .req   (pending_flags & int_mask),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    always_comb begin
        state_next = state;
        id_next    = cpu_irq_id;
        accept     = 1'b0;
        unique case (state)
            IC_IDLE: begin
                if (global_enable && enc_valid) begin
                    state_next = IC_REQUEST;
                    id_next    = enc_idx;
                end
            end
            IC_REQUEST: begin
                if (cpu_irq_ack) begin
                    accept     = 1'b1;
                    state_next = IC_SERVICE;
                end else if (!global_enable || !int_mask[cpu_irq_id] ||
                             (clear_pending[cpu_irq_id] && !int_req[cpu_irq_id])) begin
                    // Withdraw; a same-edge re-pulse keeps pending set, so the
                    // request is not withdrawn in that case.
                    state_next = IC_IDLE;
                end
            end
            IC_SERVICE: begin
                if (cpu_irq_done) begin
                    state_next = IC_IDLE;
                end
            end
            default: state_next = IC_IDLE;
        endcase
    end

    always_comb begin
        clr_vec = clear_pending;
        if (accept) begin
            clr_vec[cpu_irq_id] = 1'b1;
        end
        // New pulses take precedence over any clear on the same edge.
        pending_next = (pending_flags & ~clr_vec) | int_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IC_IDLE;
            cpu_irq       <= 1'b0;
            cpu_irq_id    <= '0;
            in_service    <= 1'b0;
            pending_flags <= '0;
        end else begin
            state         <= state_next;
            cpu_irq       <= (state_next == IC_REQUEST);
            cpu_irq_id    <= id_next;
            in_service    <= (state_next == IC_SERVICE);
            pending_flags <= pending_next;
        end
    end

`ifdef INT_OVERFLOW_FLAG_EN
    logic [N_SOURCES-1:0] overflow_q;

    // A pulse on a source that stays pending through this edge is a lost request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= '0;
        end else begin
            overflow_q <= (overflow_q & ~clear_pending) |
                          (int_req & pending_flags & ~clr_vec);
        end
    end

    assign overflow_flags = overflow_q;
`else
    assign overflow_flags = '0;
`endif

endmodule
